// File: rtl/gate_model_bist.sv
// gate_model_bist: LFSR stimulus generator and MISR response compactor for self-testing gate netlists.
// Optional golden-signature compare (gold_i/pass_o) is built when GATE_BIST_GOLDEN_EN is defined.
module gate_model_bist #(
    parameter int              IN_W      = 22,
    parameter int              OUT_W     = 10,
    parameter logic [IN_W-1:0] LFSR_TAPS = 22'h300000,
    parameter logic [OUT_W-1:0] MISR_TAPS = 10'h240,
    parameter int              CNT_W     = 16,
    parameter int              RESP_LAT  = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [IN_W-1:0]  seed_i,
    input  logic [CNT_W-1:0] npat_i,
    output logic [IN_W-1:0]  pat_o,
    input  logic [OUT_W-1:0] resp_i,
    output logic             busy_o,
    output logic             done_o,
`ifdef GATE_BIST_GOLDEN_EN
    input  logic [OUT_W-1:0] gold_i,
    output logic             pass_o,
`endif
    output logic [OUT_W-1:0] sig_o
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'((RESP_LAT > 0) ? RESP_LAT - 1 : 0);

    state_t            state;
    logic [IN_W-1:0]   lfsr;
    logic [OUT_W-1:0]  misr;
    logic [CNT_W-1:0]  cnt;
    logic [RESP_LAT:0] v;

    logic [IN_W-1:0]   seed_g;
    logic [OUT_W-1:0]  misr_nxt;
    logic [RESP_LAT:0] v_nxt;
    logic              issue;

    function automatic logic [IN_W-1:0] lfsr_step(input logic [IN_W-1:0] x);
        return {x[IN_W-2:0], ^(x & LFSR_TAPS)};
    endfunction

    // start_i is a request with no ready: it is taken only on a cycle where the FSM is IDLE;
    // a request while busy or in DONE is dropped, never queued. The first pattern goes out
    // on the accepting edge so that the last capture lands exactly on the DONE edge.
    always_comb begin
        seed_g = (seed_i == '0) ? {{(IN_W-1){1'b0}}, 1'b1} : seed_i;
        issue  = (state == RUN) || ((state == IDLE) && start_i && (npat_i != '0));
    end

    always_comb begin
        misr_nxt = misr;
        if (v[RESP_LAT])
            misr_nxt = {misr[OUT_W-2:0], ^(misr & MISR_TAPS)} ^ resp_i;
    end

    // v[i] marks that the pattern issued i+1 edges ago is still awaiting capture.
    if (RESP_LAT == 0) begin : g_pipe0
        assign v_nxt = issue;
    end else begin : g_pipe
        assign v_nxt = {v[RESP_LAT-1:0], issue};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            lfsr   <= '0;
            misr   <= '0;
            cnt    <= '0;
            v      <= '0;
            pat_o  <= '0;
            busy_o <= 1'b0;
            done_o <= 1'b0;
            sig_o  <= '0;
`ifdef GATE_BIST_GOLDEN_EN
            pass_o <= 1'b0;
`endif
        end else begin
            v      <= v_nxt;
            misr   <= misr_nxt;
            done_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_i) begin
`ifdef GATE_BIST_GOLDEN_EN
                        pass_o <= 1'b0;
`endif
                        misr <= '0;
                        if (npat_i == '0) begin
                            state <= DONE;
                        end else begin
                            pat_o  <= seed_g;
                            lfsr   <= lfsr_step(seed_g);
                            busy_o <= 1'b1;
                            if (npat_i != CNT_W'(1)) begin
                                cnt   <= npat_i - CNT_W'(1);
                                state <= RUN;
                            end else if (RESP_LAT == 0) begin
                                state <= DONE;
                            end else begin
                                cnt   <= DRAIN_LOAD;
                                state <= DRAIN;
                            end
                        end
                    end
                end
                RUN: begin
                    pat_o <= lfsr;
                    lfsr  <= lfsr_step(lfsr);
                    cnt   <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        if (RESP_LAT == 0) begin
                            state <= DONE;
                        end else begin
                            cnt   <= DRAIN_LOAD;
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (cnt == '0)
                        state <= DONE;
                    else
                        cnt <= cnt - CNT_W'(1);
                end
                DONE: begin
                    // The final response is folded in on this same edge.
                    done_o <= 1'b1;
                    busy_o <= 1'b0;
                    sig_o  <= misr_nxt;
`ifdef GATE_BIST_GOLDEN_EN
                    pass_o <= (misr_nxt == gold_i);
`endif
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
